// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial add/subtract sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Counter width for a W-bit operand; never narrower than one bit.
  function automatic int cnt_w(input int w);
    int c;
    c = $clog2(w);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand and result handshakes of the bit-serial add/subtract sequencer.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             cin;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, op_a, op_b, sub, cin, res_ready,
    input  in_ready, res_valid, result, cout, ovf, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, cin, res_ready,
    output in_ready, res_valid, result, cout, ovf, busy
  );

endinterface

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full adder cell shared by the serial arithmetic blocks.
module fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full-adder cell walks the operands LSB first,
// sum bits shift into the result register from the top.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int             CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             fa_sum, fa_carry;

  fa u_fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    result_d = result_q;
    count_d  = count_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.op_a;
          // Subtraction is A + ~B + 1, so cin is irrelevant there.
          b_sh_d  = bus.sub ? ~bus.op_b : bus.op_b;
          carry_d = bus.sub | bus.cin;
          count_d = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        a_sh_d              = a_sh_q >> 1;
        b_sh_d              = b_sh_q >> 1;
        result_d            = result_q >> 1;
        result_d[WIDTH-1]   = fa_sum;
        carry_d             = fa_carry;
        if (count_q == LAST) begin
          cout_d  = fa_carry;
          // carry_q is the carry into the MSB on the final bit.
          ovf_d   = carry_q ^ fa_carry;
          state_d = DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      count_q  <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      result_q <= result_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.res_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN) || (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Table-driven, scoreboarded bench for the bit-serial add/subtract sequencer.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             ovf;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    exp_t             e;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // The two handshakes are mutually exclusive on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (bus.in_ready && bus.res_valid) begin
        errors++;
        $display("FAIL ready_valid_overlap: in_ready=%0b res_valid=%0b", bus.in_ready, bus.res_valid);
      end
    end
  end

  // Whole-word reference: subtraction as A + ~B + 1, overflow from carry into MSB.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic s, input logic c);
    exp_t     m;
    logic [7:0] bb;
    logic       c0;
    logic [8:0] full;
    logic [7:0] low;
    bb   = s ? ~b : b;
    c0   = s ? 1'b1 : c;
    full = {1'b0, a} + {1'b0, bb} + {8'd0, c0};
    low  = {1'b0, a[6:0]} + {1'b0, bb[6:0]} + {7'd0, c0};
    m.res  = full[7:0];
    m.cout = full[8];
    m.ovf  = low[7] ^ full[8];
    return m;
  endfunction

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic c, input exp_t e, input int hold);
    int   n;
    exp_t want;
    logic [7:0] held;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.op_a = a; bus.op_b = b; bus.sub = s; bus.cin = c; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    sb.push_back(e);
    // Scramble the operand inputs: the running op must not see them.
    bus.op_a = 8'($urandom); bus.op_b = 8'($urandom);
    bus.sub  = 1'($urandom); bus.cin  = 1'($urandom);
    chk({tag, " busy"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.res_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(WIDTH));
    if (sb.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 32'd0, 32'd1);
      return;
    end
    want = sb.pop_front();
    chk({tag, " result"}, 32'(bus.result), 32'(want.res));
    chk({tag, " cout"},   32'(bus.cout),   32'(want.cout));
    chk({tag, " ovf"},    32'(bus.ovf),    32'(want.ovf));
    held = bus.result;
    for (int i = 0; i < hold; i++) begin
      bus.op_a = 8'($urandom); bus.op_b = 8'($urandom); bus.in_valid = 1'b1;
      @(posedge clk); #1;
      chk({tag, " hold res_valid"}, 32'(bus.res_valid), 32'd1);
      chk({tag, " hold in_ready"},  32'(bus.in_ready),  32'd0);
      chk({tag, " hold result"},    32'(bus.result),    32'(held));
    end
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk({tag, " back_idle"},   32'(bus.in_ready),  32'd1);
    chk({tag, " valid_drop"},  32'(bus.res_valid), 32'd0);
    chk({tag, " result_kept"}, 32'(bus.result),    32'(want.res));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, " res_valid"}, 32'(bus.res_valid), 32'd0);
    chk({tag, " busy"},      32'(bus.busy),      32'd0);
    chk({tag, " result"},    32'(bus.result),    32'd0);
    chk({tag, " cout"},      32'(bus.cout),      32'd0);
    chk({tag, " ovf"},       32'(bus.ovf),       32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'h3C, 8'h0F, 1'b0, 1'b0, '{8'h4B, 1'b0, 1'b0}};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b0}};
    vecs[2] = '{8'h80, 8'h80, 1'b0, 1'b1, '{8'h01, 1'b1, 1'b1}};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, '{8'h80, 1'b0, 1'b1}};
    vecs[4] = '{8'h05, 8'h07, 1'b1, 1'b1, '{8'hFE, 1'b0, 1'b0}};
    vecs[5] = '{8'h05, 8'h07, 1'b1, 1'b0, '{8'hFE, 1'b0, 1'b0}};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 1'b0, '{8'h00, 1'b1, 1'b0}};
    vecs[7] = '{8'h80, 8'h01, 1'b1, 1'b0, '{8'h7F, 1'b1, 1'b1}};
    vecs[8] = '{8'hFF, 8'hFF, 1'b0, 1'b1, '{8'hFF, 1'b1, 1'b0}};
    vecs[9] = '{8'h40, 8'h40, 1'b0, 1'b0, '{8'h80, 1'b0, 1'b1}};

    bus.in_valid = 1'b0; bus.res_ready = 1'b0;
    bus.op_a = '0; bus.op_b = '0; bus.sub = 1'b0; bus.cin = 1'b0;

    #2;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, vecs[i].e, 0);

    for (int i = 0; i < 8; i++) begin
      logic [7:0] a, b;
      logic       s, c;
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom); c = 1'($urandom);
      run_op($sformatf("rand%0d", i), a, b, s, c, model(a, b, s, c), 0);
    end

    // Consumer stalls while the producer keeps offering new operands.
    run_op("stall", 8'h3C, 8'h0F, 1'b0, 1'b0, '{8'h4B, 1'b0, 1'b0}, 5);
    run_op("after_stall", 8'h11, 8'h22, 1'b0, 1'b0, '{8'h33, 1'b0, 1'b0}, 0);

    // Asynchronous reset with count at 4 mid-RUN.
    bus.op_a = 8'hFF; bus.op_b = 8'h01; bus.sub = 1'b0; bus.cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrun busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_reset", 8'h01, 8'h01, 1'b0, 1'b0, '{8'h02, 1'b0, 1'b0}, 0);

    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
